cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 31 +++
 rtl/cpu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: instruction/immediate fetch, register-file and data-memory
// write strobes, and status flags.
interface cpu_sequencer_if;
  logic [15:0] instr;
  logic [15:0] N;
  logic [15:0] rddata;
  logic        jump;
  logic [15:0] pc;
  logic [15:0] instr_addr1;
  logic [15:0] instr_addr2;
  logic [15:0] ir;
  logic [15:0] imm;
  logic        rd_wen;
  logic        rs_wen;
  logic        data_wen1;
  logic        data_wen2;
  logic        halted;
  logic        stack_err;

  modport master (
    input  instr, N, rddata, jump,
    output pc, instr_addr1, instr_addr2, ir, imm,
           rd_wen, rs_wen, data_wen1, data_wen2, halted, stack_err
  );

  modport slave (
    output instr, N, rddata, jump,
    input  pc, instr_addr1, instr_addr2, ir, imm,
           rd_wen, rs_wen, data_wen1, data_wen2, halted, stack_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: non-overlapped FETCH/DECODE/EXEC(/MEMWAIT) instruction
// sequencer with PC, instruction and immediate registers.
// Optional feature macro CALL_STACK_EN: 4-entry return stack for CAL/RTN;
// without it CAL/RTN behave as NOP and stack_err is tied low.
module cpu_sequencer (
  input logic               clk,
  input logic               reset,
  cpu_sequencer_if.master   bus
);

  localparam int unsigned W = 16;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_MEMWAIT = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [4:0] OP5_STP = 5'b11111;
  localparam logic [4:0] OP5_PST = 5'b10010;
  localparam logic [4:0] OP5_PLD = 5'b10000;
  localparam logic [4:0] OP5_CAL = 5'b00001;
  localparam logic [4:0] OP5_RTN = 5'b11100;

  localparam logic [3:0] OP4_CMP = 4'b0001;
  localparam logic [3:0] OP4_JMP = 4'b0010;

  logic [2:0]   state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] imm_q, imm_d;

  logic [4:0]   op5_c;
  logic [3:0]   op4_c;
  logic [W-1:0] pc_seq_c;
  logic         alu_op_c;

  assign op5_c    = ir_q[15:11];
  assign op4_c    = ir_q[15:12];
  // Type-I instructions carry an immediate word and occupy two slots.
  assign pc_seq_c = pc_q + (ir_q[11] ? W'(2) : W'(1));

  // Register-writing ALU/move class.
  always_comb begin
    alu_op_c = 1'b0;
    case (op4_c)
      4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1011, 4'b1100, 4'b1101: alu_op_c = 1'b1;
      default:                   alu_op_c = 1'b0;
    endcase
  end

`ifdef CALL_STACK_EN
  logic [W-1:0] stk_q [4];
  logic [2:0]   sp_q, sp_d;
  logic         stack_err_q, stack_err_d;
  logic         push_c;

  // Stack pointer and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= 3'd0;
      stack_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Return-address storage; contents are only meaningful below sp.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      stk_q[sp_q[1:0]] <= pc_q + W'(2);
    end
  end

  assign bus.stack_err = stack_err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  // Sequencer state and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // Next-state and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
`ifdef CALL_STACK_EN
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    push_c      = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = bus.instr;
        imm_d   = bus.N;
        state_d = (bus.instr[15:11] == OP5_STP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_seq_c;
        if (op5_c == OP5_PLD) begin
          // PC advances once the load write-back has happened.
          state_d = S_MEMWAIT;
          pc_d    = pc_q;
        end else if (op5_c == OP5_PST) begin
          pc_d = pc_seq_c;
`ifdef CALL_STACK_EN
        end else if (op5_c == OP5_CAL) begin
          if (sp_q == 3'd4) begin
            stack_err_d = 1'b1;
            pc_d        = pc_q;
            state_d     = S_HALT;
          end else begin
            push_c = 1'b1;
            sp_d   = sp_q + 3'd1;
            pc_d   = imm_q;
          end
        end else if (op5_c == OP5_RTN) begin
          if (sp_q == 3'd0) begin
            stack_err_d = 1'b1;
            pc_d        = pc_q;
            state_d     = S_HALT;
          end else begin
            sp_d = sp_q - 3'd1;
            pc_d = stk_q[sp_q[1:0] - 2'd1];
          end
`endif
        end else if (op4_c == OP4_CMP) begin
          pc_d = pc_seq_c + (bus.jump ? W'(ir_q[1:0]) : W'(0));
        end else if (op4_c == OP4_JMP) begin
          pc_d = ir_q[11] ? imm_q : bus.rddata;
        end
      end
      S_MEMWAIT: begin
        pc_d    = pc_seq_c;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write strobes decoded from state; reset suppresses any in-flight write.
  always_comb begin
    bus.rd_wen    = 1'b0;
    bus.rs_wen    = 1'b0;
    bus.data_wen1 = 1'b0;
    bus.data_wen2 = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (op5_c == OP5_PST) begin
          bus.data_wen1 = ir_q[3];
          bus.data_wen2 = ir_q[2];
        end else if (alu_op_c) begin
          bus.rd_wen = 1'b1;
        end
      end
      S_MEMWAIT: begin
        bus.rd_wen = ir_q[3];
        bus.rs_wen = ir_q[2];
      end
      default: begin
        bus.rd_wen = 1'b0;
      end
    endcase
    if (reset) begin
      bus.rd_wen    = 1'b0;
      bus.rs_wen    = 1'b0;
      bus.data_wen1 = 1'b0;
      bus.data_wen2 = 1'b0;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_addr1 = pc_q;
  assign bus.instr_addr2 = pc_q + W'(1);
  assign bus.ir          = ir_q;
  assign bus.imm         = imm_q;
  assign bus.halted      = (state_q == S_HALT);

endmodule
